// File: rtl/tia_video_capture.sv
// Decodes TIA sync/blank pins into beam coordinates and queues visible pixels on a valid/ready
// stream. Define TIA_CAPTURE_LINE_CHECK_EN to add line_len_err and lines_per_frame.
module tia_video_capture #(
    parameter int unsigned VSYNC_MIN_CLKS = 456,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned LINE_CLKS      = 228
) (
    input  logic       clk,
    input  logic       reset_bar,
    input  logic       syn,
    input  logic       blk_bar,
    input  logic [2:0] l,
    input  logic [3:0] c,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic [7:0] pix_x,
    output logic [8:0] pix_y,
    output logic [2:0] pix_lum,
    output logic [3:0] pix_col,
    output logic       frame_start,
    output logic [7:0] frame_count,
    output logic       locked,
    output logic       overflow,
    input  logic       ovf_clr
`ifdef TIA_CAPTURE_LINE_CHECK_EN
    ,
    output logic       line_len_err,
    output logic [8:0] lines_per_frame
`endif
);
    localparam int unsigned RunW  = $clog2(VSYNC_MIN_CLKS + 1);
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = AddrW + 1;
    localparam logic [RunW-1:0] RunMax  = RunW'(VSYNC_MIN_CLKS);
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || LINE_CLKS > 510)
    begin : g_param_check
        $error("tia_video_capture: unsupported parameter values");
    end

    typedef enum logic {StSearch, StLocked} state_e;

    typedef struct packed {
        logic [7:0] x;
        logic [8:0] y;
        logic [2:0] lum;
        logic [3:0] col;
    } pix_t;

    state_e            state_q, state_d;
    logic              syn_q, blk_q;
    logic [2:0]        l_q;
    logic [3:0]        c_q;
    logic [RunW-1:0]   run_q, run_d;
    logic [7:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic [7:0]        frame_count_q, frame_count_d;
    logic              overflow_q, overflow_d;
    logic              cap_q, cap_d;
    pix_t              cap_pix_q, cap_pix_d;
    logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    pix_t              mem_q [FIFO_DEPTH];
    pix_t              mem_d [FIFO_DEPTH];

    logic sync_fall, vsync_fall, hsync_fall;
    logic pop, push, drop, full;
    pix_t head;

    // A nonzero run count means syn_q was high on the previous clock.
    assign sync_fall  = !syn_q && (run_q != '0);
    assign vsync_fall = sync_fall && (run_q >= RunMax);
    assign hsync_fall = sync_fall && !vsync_fall;

    assign full = (cnt_q == CntFull);
    assign pop  = pix_valid && pix_ready;
    assign push = cap_q && (!full || pop);
    assign drop = cap_q && full && !pop;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSearch: if (vsync_fall) state_d = StLocked;
            StLocked: state_d = StLocked;
            default:  state_d = StSearch;
        endcase
    end

    always_comb begin
        run_d         = '0;
        x_d           = x_q;
        y_d           = y_q;
        frame_count_d = frame_count_q;

        if (syn_q) run_d = (run_q == RunMax) ? run_q : run_q + 1'b1;

        if (sync_fall)             x_d = '0;
        else if (x_q != 8'hFF)     x_d = x_q + 8'd1;

        if (vsync_fall) begin
            y_d           = '0;
            frame_count_d = frame_count_q + 8'd1;
        end else if (hsync_fall && state_q == StLocked && y_q != 9'h1FF) begin
            y_d = y_q + 9'd1;
        end
    end

    // Capture is staged one clock so the FIFO write lands two edges after the input sample.
    always_comb begin
        cap_d     = (state_q == StLocked) && !syn_q && blk_q;
        cap_pix_d = '{x: x_q, y: y_q, lum: l_q, col: c_q};

        wr_ptr_d = push ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AddrW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase

        overflow_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = cap_pix_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_bar) begin
            state_q       <= StSearch;
            syn_q         <= 1'b0;
            blk_q         <= 1'b0;
            l_q           <= '0;
            c_q           <= '0;
            run_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            frame_count_q <= '0;
            overflow_q    <= 1'b0;
            cap_q         <= 1'b0;
            cap_pix_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            syn_q         <= syn;
            blk_q         <= blk_bar;
            l_q           <= l;
            c_q           <= c;
            run_q         <= run_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_count_q <= frame_count_d;
            overflow_q    <= overflow_d;
            cap_q         <= cap_d;
            cap_pix_q     <= cap_pix_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head        = mem_q[rd_ptr_q];
    assign pix_valid   = (cnt_q != '0);
    assign pix_x       = pix_valid ? head.x   : '0;
    assign pix_y       = pix_valid ? head.y   : '0;
    assign pix_lum     = pix_valid ? head.lum : '0;
    assign pix_col     = pix_valid ? head.col : '0;
    assign frame_start = vsync_fall;
    assign frame_count = frame_count_q;
    assign locked      = (state_q == StLocked);
    assign overflow    = overflow_q;

`ifdef TIA_CAPTURE_LINE_CHECK_EN
    localparam int unsigned LineW = $clog2(LINE_CLKS + 2);

    logic [LineW-1:0] line_cnt_q, line_cnt_d;
    logic             line_meas_q, line_meas_d;
    logic             line_err_q, line_err_d;
    logic [8:0]       lpf_q, lpf_d;

    // line_cnt_q equals the clocks elapsed since the last HSYNC fall (saturating).
    always_comb begin
        line_cnt_d  = (line_cnt_q == '1) ? line_cnt_q : line_cnt_q + 1'b1;
        line_meas_d = line_meas_q;
        line_err_d  = ovf_clr ? 1'b0 : line_err_q;
        lpf_d       = lpf_q;
        if (vsync_fall) begin
            line_meas_d = 1'b0;
            lpf_d       = y_q;
        end else if (hsync_fall && state_q == StLocked) begin
            line_cnt_d  = LineW'(1);
            line_meas_d = 1'b1;
            if (line_meas_q && line_cnt_q != LineW'(LINE_CLKS)) line_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_bar) begin
            line_cnt_q  <= '0;
            line_meas_q <= 1'b0;
            line_err_q  <= 1'b0;
            lpf_q       <= '0;
        end else begin
            line_cnt_q  <= line_cnt_d;
            line_meas_q <= line_meas_d;
            line_err_q  <= line_err_d;
            lpf_q       <= lpf_d;
        end
    end

    assign line_len_err    = line_err_q;
    assign lines_per_frame = lpf_q;
`endif

endmodule

// File: tb/tb_tia_video_capture.sv
// Scoreboard bench for tia_video_capture: stimulus pushes expected pixels, a negedge monitor
// pops and compares them whenever the DUT hands a pixel over.
module tb_tia_video_capture;
    logic       clk = 1'b0;
    logic       reset_bar, syn, blk_bar, pix_ready, ovf_clr;
    logic [2:0] l;
    logic [3:0] c;
    logic       pix_valid, frame_start, locked, overflow;
    logic [7:0] pix_x, frame_count;
    logic [8:0] pix_y;
    logic [2:0] pix_lum;
    logic [3:0] pix_col;
`ifdef TIA_CAPTURE_LINE_CHECK_EN
    logic       line_len_err;
    logic [8:0] lines_per_frame;
`endif

    always #5 clk = ~clk;

    tia_video_capture #(
        .VSYNC_MIN_CLKS(456),
        .FIFO_DEPTH    (8),
        .LINE_CLKS     (228)
    ) dut (
        .clk            (clk),
        .reset_bar      (reset_bar),
        .syn            (syn),
        .blk_bar        (blk_bar),
        .l              (l),
        .c              (c),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .pix_lum        (pix_lum),
        .pix_col        (pix_col),
        .frame_start    (frame_start),
        .frame_count    (frame_count),
        .locked         (locked),
        .overflow       (overflow),
        .ovf_clr        (ovf_clr)
`ifdef TIA_CAPTURE_LINE_CHECK_EN
        ,
        .line_len_err   (line_len_err),
        .lines_per_frame(lines_per_frame)
`endif
    );

    int          n_total = 0;
    int          n_pass  = 0;
    logic [23:0] exp_q[$];
    bit          mon_en  = 1'b0;
    int          fs_cnt;
    int          vseen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: a pop happens at the next rising edge when valid && ready at the falling edge.
    always @(negedge clk) begin
        if (mon_en && pix_valid && pix_ready) begin
            if (exp_q.size() == 0)
                chk("unexpected_pop", {8'd0, pix_x, pix_y, pix_lum, pix_col}, 32'hFFFF_FFFF);
            else
                chk("pop_pixel", {8'd0, pix_x, pix_y, pix_lum, pix_col}, {8'd0, exp_q.pop_front()});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_frame();
        fs_cnt  = 0;
        syn     = 1'b1;
        blk_bar = 1'b0;
        repeat (456) begin
            cyc();
            fs_cnt += int'(frame_start);
        end
        syn = 1'b0;
        repeat (10) begin
            cyc();
            fs_cnt += int'(frame_start);
        end
    endtask

    // Input driven on loop index i is sampled with beam x = i-1 (x is 0 on the clock after the fall).
    task automatic line(input int sync_len, input int first_x, input int n_vis, input int n_exp,
                        input logic [8:0] y_exp, input bit chk_lat);
        fs_cnt  = 0;
        vseen   = 0;
        syn     = 1'b1;
        blk_bar = 1'b0;
        repeat (sync_len) begin
            cyc();
            fs_cnt += int'(frame_start);
        end
        for (int k = 0; k < n_exp; k++) exp_q.push_back({8'(first_x + k), y_exp, 3'd5, 4'hA});
        for (int i = 0; i < first_x + n_vis + 40; i++) begin
            syn     = 1'b0;
            blk_bar = (i > first_x) && (i <= first_x + n_vis);
            l       = 3'd5;
            c       = 4'hA;
            cyc();
            fs_cnt += int'(frame_start);
            vseen  += int'(pix_valid);
            if (chk_lat && i == first_x + 2) chk("latency_edge_k1", pix_valid, 1'b0);
            if (chk_lat && i == first_x + 3) chk("latency_edge_k2", pix_valid, 1'b1);
        end
        blk_bar = 1'b0;
    endtask

    initial begin
        reset_bar = 1'b0;
        syn       = 1'b0;
        blk_bar   = 1'b0;
        l         = '0;
        c         = '0;
        pix_ready = 1'b1;
        ovf_clr   = 1'b0;

        repeat (3) begin
            syn     = 1'($urandom);
            blk_bar = 1'($urandom);
            l       = 3'($urandom);
            c       = 4'($urandom);
            cyc();
        end
        chk("rst_pix_valid", pix_valid, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_frame_count", frame_count, 8'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_frame_start", frame_start, 1'b0);
        reset_bar = 1'b1;
        syn       = 1'b0;
        blk_bar   = 1'b0;
        cyc();
        mon_en = 1'b1;

        // Unlocked: visible pixels must not be captured.
        vseen   = 0;
        blk_bar = 1'b1;
        repeat (8) begin
            cyc();
            vseen += int'(pix_valid);
        end
        blk_bar = 1'b0;
        chk("search_no_capture", vseen, 0);

        vsync_frame();
        chk("vsync_frame_start_pulses", fs_cnt, 1);
        chk("vsync_locked", locked, 1'b1);
        chk("vsync_frame_count", frame_count, 8'd1);

        line(16, 68, 4, 4, 9'd1, 1'b1);
        chk("hsync_no_frame_start", fs_cnt, 0);
        chk("hsync_frame_count", frame_count, 8'd1);

        pix_ready = 1'b0;
        line(16, 68, 20, 8, 9'd2, 1'b0);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_head_x", pix_x, 8'd68);
        cyc();
        chk("ovf_head_stable_valid", pix_valid, 1'b1);
        chk("ovf_head_stable_x", pix_x, 8'd68);
        pix_ready = 1'b1;
        repeat (20) cyc();
        chk("ovf_drained", pix_valid, 1'b0);
        chk("ovf_sticky", overflow, 1'b1);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 1'b0);

        line(300, 68, 1, 1, 9'd3, 1'b0);
        chk("short_no_frame_start", fs_cnt, 0);
        chk("short_frame_count", frame_count, 8'd1);
        chk("short_locked", locked, 1'b1);

        vsync_frame();
        chk("vsync2_frame_start_pulses", fs_cnt, 1);
        chk("vsync2_frame_count", frame_count, 8'd2);
        line(16, 40, 2, 2, 9'd1, 1'b0);

        pix_ready = 1'b0;
        line(16, 68, 5, 0, 9'd0, 1'b0);
        chk("midrst_queued", pix_valid, 1'b1);
        reset_bar = 1'b0;
        cyc();
        chk("midrst_pix_valid", pix_valid, 1'b0);
        chk("midrst_locked", locked, 1'b0);
        chk("midrst_frame_count", frame_count, 8'd0);
        reset_bar = 1'b1;
        pix_ready = 1'b1;
        line(16, 68, 4, 0, 9'd0, 1'b0);
        chk("midrst_ignores_pixels", vseen, 0);

        vsync_frame();
        chk("relock_frame_count", frame_count, 8'd1);
        chk("relock_locked", locked, 1'b1);
        line(16, 68, 1, 1, 9'd1, 1'b0);
        repeat (10) cyc();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/tia_video_capture.md
Name: tia_video_capture

Overview:
- Receiver for the TIA video output stream (syn, blk_bar, l, c), sampled once per color clock.
- Recovers horizontal and vertical sync, tracks beam position (x, y) and buffers visible pixels in a FIFO.
- Presents each buffered pixel on a valid/ready stream with its coordinates.
- Sits beside the TIA model in benches and capture harnesses; consumes the TIA's video pins.

Parameters:
- VSYNC_MIN_CLKS, 456: consecutive syn-high clocks at which a pulse is classified as VSYNC.
- FIFO_DEPTH, 8: pixel FIFO entries; power of two, at least 2.
- LINE_CLKS, 228: expected hsync-to-hsync interval; used only with the optional feature.

Ports:
- clk  in  1  color clock; all logic on the rising edge.
- reset_bar  in  1  synchronous, active-low reset.
- syn  in  1  TIA sync output, treated as a level.
- blk_bar  in  1  TIA blank, active-low; 1 means the pixel is visible.
- l  in  3  luminance.
- c  in  4  color.
- pix_valid  out  1  FIFO head valid.
- pix_ready  in  1  consumer accepts the head.
- pix_x  out  8  head pixel x.
- pix_y  out  9  head pixel y.
- pix_lum  out  3  head luminance.
- pix_col  out  4  head color.
- frame_start  out  1  one-clock pulse at the end of VSYNC.
- frame_count  out  8  frames since reset; wraps.
- locked  out  1  a VSYNC has been seen since reset.
- overflow  out  1  sticky; a pixel was dropped.
- ovf_clr  in  1  clears the sticky flags.

Behaviour:
- Reset (reset_bar=0 at an edge):
  - All outputs go to 0; FIFO is flushed; counters are zeroed.
  - Takes effect mid-frame and with the FIFO non-empty; nothing survives.
- Input stage: syn, blk_bar, l and c are registered once (syn_q etc.). All decisions below use the registered values.
- run counter: counts consecutive clocks with syn_q=1 and saturates at VSYNC_MIN_CLKS. It loads 0 when syn_q=0.
- Sync fall: syn_q=0 with previous syn_q=1.
  - If run ≥ VSYNC_MIN_CLKS, it is a VSYNC fall.
  - Otherwise it is an HSYNC fall.
- State machine:
  - SEARCH: initial state. A VSYNC fall moves to LOCKED.
  - LOCKED: remains until reset.
- On a VSYNC fall, in any state:
  - y←0, x←0.
  - frame_start=1 for exactly that clock.
  - frame_count+1, wrapping 255→0.
  - locked=1.
- On an HSYNC fall: x←0. In LOCKED, y+1, saturating at 511.
- Otherwise x+1 every clock, saturating at 255.
- The first clock after any sync fall has x=0.
- Capture:
  - In LOCKED, when syn_q=0 and blk_bar_q=1, push {x, y, l_q, c_q}.
  - No capture in SEARCH or while syn_q=1.
- FIFO:
  - Registered head.
  - A pixel whose inputs are sampled at edge k appears with pix_valid=1 after edge k+2 when the FIFO was empty.
  - Pop occurs when pix_valid && pix_ready.
  - Push when full with no pop: the pixel is dropped and overflow←1. Existing entries are untouched.
  - Push when full with a pop in the same clock: the push is accepted.
  - Outputs are stable while pix_valid=1 and pix_ready=0.
- ovf_clr=1 clears overflow on the next edge. A drop in the same clock wins: overflow stays 1.

Optional Feature:
- Macro: TIA_CAPTURE_LINE_CHECK_EN.
- Defined: adds outputs line_len_err (1, sticky) and lines_per_frame (9).
  - line_len_err←1 when two consecutive HSYNC falls in LOCKED are not exactly LINE_CLKS apart.
  - A VSYNC fall restarts the interval measurement.
  - lines_per_frame latches the y value present at each VSYNC fall.
  - ovf_clr also clears line_len_err.
  - Both outputs reset to 0.
- Undefined: these ports and their logic are absent; LINE_CLKS is unused.

Test Plan:
- Reset: reset_bar=0 for 3 clocks with random inputs → pix_valid=0, locked=0, frame_count=0, overflow=0, frame_start=0.
- VSYNC: syn=1 for 456 clocks, then 0 → frame_start high exactly one clock, locked=1, frame_count=1. Internal y=0.
- HSYNC and capture, after lock, pix_ready=1:
  - Stimulus: syn=1 for 16 clocks, then 0; blk_bar=1 at x=68..71 with l=5, c=0xA.
  - Response: four pops with pix_x=68,69,70,71, pix_y=1, pix_lum=5, pix_col=0xA, in order.
- Overflow, FIFO_DEPTH=8:
  - Stimulus: pix_ready=0; 20 visible pixels starting at x=68.
  - Response: overflow=1; later pops give exactly x=68..75. ovf_clr=1 then clears overflow.
- Short pulse: after lock, syn=1 for 300 clocks → treated as HSYNC. y increments; no frame_start; frame_count unchanged.
- Reset mid-operation: 5 entries queued, reset_bar=0 for 1 clock → pix_valid=0 and locked=0 the next clock. Visible pixels are ignored until the next VSYNC fall.
